// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares the single data-memory port between the two FAM execution lanes.
// A lone request passes straight through with no added latency; two requests
// in the same cycle are issued in program order over two cycles, with a
// one-cycle pipeline stall raised during the first of them.
// Optional feature macro: DM_ARB_PERF_EN adds the arb_conflicts counter port.
module dm_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // lane 0
    input  logic              l0_rd,
    input  logic [3:0]        l0_wea,
    input  logic [ADDR_W-1:0] l0_addr,
    input  logic [DATA_W-1:0] l0_wdata,
    input  logic              l0_num,
    output logic [DATA_W-1:0] l0_rdata,
    // lane 1
    input  logic              l1_rd,
    input  logic [3:0]        l1_wea,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic [DATA_W-1:0] l1_wdata,
    input  logic              l1_num,
    output logic [DATA_W-1:0] l1_rdata,
    // data RAM
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wea,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    // pipeline stall
    output logic              arb_stop
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]       arb_conflicts
`endif
);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t state_q, state_d;

    logic req0, req1, both_req;
    logic l1_older;

    // Shadow of the younger access, the word returned to the older lane,
    // and which lane is the younger one.
    logic [3:0]        sh_wea_q;
    logic [ADDR_W-1:0] sh_addr_q;
    logic [DATA_W-1:0] sh_wdata_q;
    logic [DATA_W-1:0] hold_q;
    logic              young_l1_q;

    logic [3:0]        sh_wea_d;
    logic [ADDR_W-1:0] sh_addr_d;
    logic [DATA_W-1:0] sh_wdata_d;
    logic [DATA_W-1:0] hold_d;
    logic              young_l1_d;

    logic              capture;

    assign req0     = l0_rd | (|l0_wea);
    assign req1     = l1_rd | (|l1_wea);
    assign both_req = req0 & req1;

    // Lane 1 is older only when it carries the lower tag; ties favour lane 0.
    assign l1_older = l0_num & ~l1_num;

    assign capture  = (state_q == IDLE) && both_req;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a conflict costs exactly one extra cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (both_req) state_d = SECOND;
            SECOND:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture data for the second access: the younger lane's request and the older lane's word.
    // The RAM read has no enable, so the younger lane's rd flag needs no shadow copy.
    always_comb begin
        sh_wea_d   = sh_wea_q;
        sh_addr_d  = sh_addr_q;
        sh_wdata_d = sh_wdata_q;
        hold_d     = hold_q;
        young_l1_d = young_l1_q;
        if (capture) begin
            hold_d     = dm_rdata;
            young_l1_d = ~l1_older;
            if (l1_older) begin
                sh_wea_d   = l0_wea;
                sh_addr_d  = l0_addr;
                sh_wdata_d = l0_wdata;
            end else begin
                sh_wea_d   = l1_wea;
                sh_addr_d  = l1_addr;
                sh_wdata_d = l1_wdata;
            end
        end
    end

    // Shadow and hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_wea_q   <= '0;
            sh_addr_q  <= '0;
            sh_wdata_q <= '0;
            hold_q     <= '0;
            young_l1_q <= 1'b0;
        end else begin
            sh_wea_q   <= sh_wea_d;
            sh_addr_q  <= sh_addr_d;
            sh_wdata_q <= sh_wdata_d;
            hold_q     <= hold_d;
            young_l1_q <= young_l1_d;
        end
    end

    // Output logic: steer the RAM port and return data per state.
    // Outputs are held at zero while rst is high so an access pending in SECOND never reaches the RAM.
    always_comb begin
        dm_addr  = '0;
        dm_wea   = '0;
        dm_wdata = '0;
        l0_rdata = '0;
        l1_rdata = '0;
        arb_stop = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (both_req) begin
                        arb_stop = 1'b1;
                        if (l1_older) begin
                            dm_addr  = l1_addr;
                            dm_wea   = l1_wea;
                            dm_wdata = l1_wdata;
                            l1_rdata = dm_rdata;
                        end else begin
                            dm_addr  = l0_addr;
                            dm_wea   = l0_wea;
                            dm_wdata = l0_wdata;
                            l0_rdata = dm_rdata;
                        end
                    end else if (req0) begin
                        dm_addr  = l0_addr;
                        dm_wea   = l0_wea;
                        dm_wdata = l0_wdata;
                        l0_rdata = dm_rdata;
                    end else if (req1) begin
                        dm_addr  = l1_addr;
                        dm_wea   = l1_wea;
                        dm_wdata = l1_wdata;
                        l1_rdata = dm_rdata;
                    end
                end
                SECOND: begin
                    dm_addr  = sh_addr_q;
                    dm_wea   = sh_wea_q;
                    dm_wdata = sh_wdata_q;
                    if (young_l1_q) begin
                        l1_rdata = dm_rdata;
                        l0_rdata = hold_q;
                    end else begin
                        l0_rdata = dm_rdata;
                        l1_rdata = hold_q;
                    end
                end
                default: begin
                    dm_addr = '0;
                end
            endcase
        end
    end

`ifdef DM_ARB_PERF_EN
    logic [31:0] conflicts_q;

    // Count IDLE->SECOND transitions, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflicts_q <= '0;
        end else if (capture && (conflicts_q != '1)) begin
            conflicts_q <= conflicts_q + 32'd1;
        end
    end

    assign arb_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed table, hand-written
// conflict/reset sequences, and random traffic against a transaction-level model.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        l0_rd, l1_rd, l0_num, l1_num;
    logic [3:0]  l0_wea, l1_wea;
    logic [31:0] l0_addr, l1_addr, l0_wdata, l1_wdata;
    logic [31:0] l0_rdata, l1_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wea;
    logic        arb_stop;
`ifdef DM_ARB_PERF_EN
    logic [31:0] arb_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .l0_rd    (l0_rd),
        .l0_wea   (l0_wea),
        .l0_addr  (l0_addr),
        .l0_wdata (l0_wdata),
        .l0_num   (l0_num),
        .l0_rdata (l0_rdata),
        .l1_rd    (l1_rd),
        .l1_wea   (l1_wea),
        .l1_addr  (l1_addr),
        .l1_wdata (l1_wdata),
        .l1_num   (l1_num),
        .l1_rdata (l1_rdata),
        .dm_addr  (dm_addr),
        .dm_wea   (dm_wea),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .arb_stop (arb_stop)
`ifdef DM_ARB_PERF_EN
        ,
        .arb_conflicts (arb_conflicts)
`endif
    );

    // Behavioural data RAM: 64 words, byte-write, combinational read.
    logic [31:0] ram [0:63];
    logic        ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + 32'(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (dm_wea[b]) ram[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
        end
    end

    assign dm_rdata = ram[dm_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea, input logic [3:0] ew,
                           input logic [31:0] ed, input logic es,
                           input logic [31:0] e0, input logic [31:0] e1);
        chk({tag, ".dm_addr"},  dm_addr, ea);
        chk({tag, ".dm_wea"},   {28'd0, dm_wea}, {28'd0, ew});
        chk({tag, ".dm_wdata"}, dm_wdata, ed);
        chk({tag, ".arb_stop"}, {31'd0, arb_stop}, {31'd0, es});
        chk({tag, ".l0_rdata"}, l0_rdata, e0);
        chk({tag, ".l1_rdata"}, l1_rdata, e1);
    endtask

    task automatic set_l0(input logic rd, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic n);
        l0_rd = rd; l0_wea = w; l0_addr = a; l0_wdata = d; l0_num = n;
    endtask

    task automatic set_l1(input logic rd, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic n);
        l1_rd = rd; l1_wea = w; l1_addr = a; l1_wdata = d; l1_num = n;
    endtask

    task automatic idle_all();
        set_l0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        set_l1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r0; logic [3:0] w0; logic [31:0] a0; logic [31:0] d0; logic n0;
        logic        r1; logic [3:0] w1; logic [31:0] a1; logic [31:0] d1; logic n1;
        logic [31:0] ea; logic [3:0] ew; logic [31:0] ed; logic es;
        logic [31:0] e0; logic [31:0] e1;
    } vec_t;

    vec_t tbl [6];

    typedef struct {
        int          lane;
        logic [3:0]  wea;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic [31:0] ref_mem [0:63];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        acc_t        q[$];
        acc_t        a;
        logic [31:0] er [2];
        logic [31:0] first_word;
        logic        r0, r1, n0, n1;
        logic [3:0]  w0, w1;
        logic [31:0] a0, a1, d0, d1;

        // RAM starts as word i = 0x1000_0000 + i
        tbl[0] = '{1'b0, 4'h0, 32'h30, 32'h77, 1'b0,  1'b0, 4'h0, 32'h34, 32'h88, 1'b1,
                   32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0,  1'b0, 4'h0, 32'h0, 32'h0, 1'b0,
                   32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h1000_0004, 32'h0};
        tbl[2] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0,  1'b1, 4'h0, 32'h10, 32'h12345678, 1'b0,
                   32'h10, 4'h0, 32'h12345678, 1'b0, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0,  1'b0, 4'h3, 32'h14, 32'hCAFEF00D, 1'b1,
                   32'h14, 4'h3, 32'hCAFEF00D, 1'b0, 32'h0, 32'h1000_0005};
        tbl[4] = '{1'b1, 4'h0, 32'h14, 32'h0, 1'b1,  1'b0, 4'h0, 32'h0, 32'h0, 1'b0,
                   32'h14, 4'h0, 32'h0, 1'b0, 32'h1000_F00D, 32'h0};
        tbl[5] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0,  1'b1, 4'h8, 32'h18, 32'hAB000000, 1'b0,
                   32'h18, 4'h8, 32'hAB000000, 1'b0, 32'h0, 32'h1000_0006};

        // reset
        rst = 1'b1;
        ram_init = 1'b1;
        idle_all();
        next_cycle();
        next_cycle();
        ram_init = 1'b0;
        @(negedge clk);
        chk_all("reset", 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b0;

        // directed single-lane / idle table
        for (int i = 0; i < 6; i++) begin
            set_l0(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].n0);
            set_l1(tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].n1);
            @(negedge clk);
            chk_all($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].ew, tbl[i].ed, tbl[i].es,
                    tbl[i].e0, tbl[i].e1);
            next_cycle();
        end

        // dual load, lane1 older
        set_l0(1'b1, 4'h0, 32'h20, 32'h0, 1'b1);
        set_l1(1'b1, 4'h0, 32'h24, 32'h0, 1'b0);
        @(negedge clk);
        chk_all("dual_c0", 32'h24, 4'h0, 32'h0, 1'b1, 32'h0, 32'h1000_0009);
        next_cycle();
        @(negedge clk);
        chk_all("dual_c1", 32'h20, 4'h0, 32'h0, 1'b0, 32'h1000_0008, 32'h1000_0009);
        next_cycle();
        idle_all();
        @(negedge clk);
        chk_all("dual_after", 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // RAW: older store byte 0, younger load same word
        set_l0(1'b0, 4'h1, 32'h40, 32'h55, 1'b0);
        set_l1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1);
        @(negedge clk);
        chk_all("raw_c0", 32'h40, 4'h1, 32'h55, 1'b1, 32'h1000_0010, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all("raw_c1", 32'h40, 4'h0, 32'h0, 1'b0, 32'h1000_0010, 32'h1000_0055);
        chk("raw_byte", {24'd0, l1_rdata[7:0]}, 32'h55);
        next_cycle();
        idle_all();

        // WAW: equal tags, lane0 goes first, lane1 value remains
        set_l0(1'b0, 4'hF, 32'h80, 32'h1111, 1'b1);
        set_l1(1'b0, 4'hF, 32'h80, 32'h2222, 1'b1);
        @(negedge clk);
        chk_all("waw_c0", 32'h80, 4'hF, 32'h1111, 1'b1, 32'h1000_0020, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all("waw_c1", 32'h80, 4'hF, 32'h2222, 1'b0, 32'h1000_0020, 32'h1111);
        next_cycle();
        idle_all();
        @(negedge clk);
        chk("waw_ram", ram[32], 32'h2222);
        chk("waw_no_reissue", {28'd0, dm_wea}, 32'h0);
        next_cycle();

        // reset while in SECOND drops the younger store
        set_l0(1'b0, 4'hF, 32'h90, 32'h1111, 1'b0);
        set_l1(1'b0, 4'hF, 32'h90, 32'h2222, 1'b0);
        @(negedge clk);
        chk("rst2_c0.stop", {31'd0, arb_stop}, 32'h1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk_all("rst2_in", 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b0;
        idle_all();
        @(negedge clk);
        chk_all("rst2_after", 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("rst2_ram", ram[36], 32'h1111);
        next_cycle();

        // random traffic against a transaction-level model
        ram_init = 1'b1;
        next_cycle();
        ram_init = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);

        for (int it = 0; it < 300; it++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            w0 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            w1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            a0 = 32'hC0 + ($urandom_range(0, 7) << 2);
            a1 = 32'hC0 + ($urandom_range(0, 7) << 2);
            d0 = $urandom;
            d1 = $urandom;
            n0 = 1'($urandom_range(0, 1));
            n1 = 1'($urandom_range(0, 1));
            set_l0(r0, w0, a0, d0, n0);
            set_l1(r1, w1, a1, d1, n1);

            // accesses in program order: lower tag first, ties to lane 0
            q.delete();
            if (r0 || (w0 != 0)) begin
                a = '{0, w0, a0, d0};
                q.push_back(a);
            end
            if (r1 || (w1 != 0)) begin
                a = '{1, w1, a1, d1};
                if (q.size() == 1 && n1 < n0) q.push_front(a);
                else q.push_back(a);
            end

            if (q.size() == 0) begin
                @(negedge clk);
                chk_all($sformatf("rnd%0d_idle", it), 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
                next_cycle();
            end else begin
                first_word = 32'h0;
                for (int k = 0; k < q.size(); k++) begin
                    er[0] = 32'h0;
                    er[1] = 32'h0;
                    er[q[k].lane] = ref_mem[q[k].addr[7:2]];
                    if (k == 0) first_word = ref_mem[q[k].addr[7:2]];
                    else er[q[0].lane] = first_word;
                    @(negedge clk);
                    chk_all($sformatf("rnd%0d_%0d", it, k), q[k].addr, q[k].wea, q[k].wdata,
                            (q.size() == 2 && k == 0), er[0], er[1]);
                    for (int b = 0; b < 4; b++)
                        if (q[k].wea[b]) ref_mem[q[k].addr[7:2]][8*b +: 8] = q[k].wdata[8*b +: 8];
                    next_cycle();
                end
            end
        end
        idle_all();
        next_cycle();
        for (int i = 48; i < 56; i++) chk($sformatf("rnd_ram%0d", i), ram[i], ref_mem[i]);

`ifdef DM_ARB_PERF_EN
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set_l0(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
            set_l1(1'b1, 4'h0, 32'h4, 32'h0, 1'b1);
            next_cycle();
            next_cycle();
            idle_all();
            next_cycle();
        end
        set_l0(1'b1, 4'h0, 32'h8, 32'h0, 1'b0);
        next_cycle();
        idle_all();
        set_l1(1'b1, 4'h0, 32'hC, 32'h0, 1'b0);
        next_cycle();
        idle_all();
        @(negedge clk);
        chk("perf_count", arb_conflicts, 32'd3);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("perf_clear", arb_conflicts, 32'd0);
        next_cycle();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
